// File: rtl/tone_seq_ctrl_pkg.sv
// Shared definitions for the xylophone tone sequencer.
//   - Default widths for the up_counter timebase and the note cycle count.
//   - Default silent gap length and the minimum legal half-period.
//   - FSM state encoding (2 bits).
package tone_seq_ctrl_pkg;

    localparam int unsigned CNT_W_DEF    = 20;
    localparam int unsigned CYC_W_DEF    = 16;
    localparam int unsigned GAP_CLKS_DEF = 25000;
    localparam int unsigned MIN_PERIOD   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl: sequences an external up_counter to play one square-wave
// note at a time, followed by a fixed silent gap and a completion pulse.
//
// Ports
//   clk          system clock
//   sclr         synchronous active-high reset
//   note_valid   note request present
//   note_ready   note can be accepted (IDLE and not in reset)
//   note_period  half-period in clocks, sampled on accept (clamped to >= 2)
//   note_cycles  full tone cycles to play, sampled on accept
//   stop         abort the current note or gap
//   cnt_q        current value of the external up_counter
//   cnt_sclr     synchronous clear for the external up_counter (combinational)
//   tone_out     registered square-wave output
//   busy         high in PLAY or GAP
//   done         one-cycle pulse at the end of the gap
module tone_seq_ctrl
    import tone_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned CYC_W    = CYC_W_DEF,
    parameter int unsigned GAP_CLKS = GAP_CLKS_DEF
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [CNT_W-1:0] note_period,
    input  logic [CYC_W-1:0] note_cycles,
    input  logic             stop,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_sclr,
    output logic             tone_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CYC_W-1:0] rem_q, rem_d;
    logic             tone_q, tone_d;
    logic             done_q, done_d;
    logic             wrap;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= S_IDLE;
            per_q   <= MIN_PER;
            rem_q   <= '0;
            tone_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        rem_d   = rem_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        wrap    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tone_d = 1'b0;
                if (note_valid) begin
                    per_d   = (note_period < MIN_PER) ? MIN_PER : note_period;
                    rem_d   = note_cycles;
                    state_d = (note_cycles == '0) ? S_GAP : S_PLAY;
                end
            end
            S_PLAY: begin
                wrap = (cnt_q == per_q - 1'b1);
                if (wrap) begin
                    if (tone_q) begin
                        // Falling edge closes one full cycle.
                        tone_d = 1'b0;
                        rem_d  = rem_q - 1'b1;
                        if (rem_q == CYC_W'(1)) begin
                            state_d = S_GAP;
                        end
                    end else begin
                        tone_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                tone_d = 1'b0;
                // done is held for one cycle while still in GAP, so note_ready
                // only rises the cycle after the pulse.
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == GAP_LAST) begin
                    wrap   = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tone_d  = 1'b0;
            end
        endcase

        // Abort takes priority over any wrap in the same cycle.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            tone_d  = 1'b0;
            rem_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign cnt_sclr   = sclr | (state_q == S_IDLE) | stop | wrap;
    assign note_ready = (state_q == S_IDLE) & ~sclr;
    assign busy       = (state_q == S_PLAY) | (state_q == S_GAP);
    assign tone_out   = tone_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Self-checking bench for tone_seq_ctrl together with a behavioural up_counter.
module tb_tone_seq_ctrl;

    localparam int unsigned CW  = 20;
    localparam int unsigned YW  = 16;
    localparam int unsigned GAP = 10;

    logic          clk;
    logic          sclr;
    logic          note_valid;
    logic          note_ready;
    logic [CW-1:0] note_period;
    logic [YW-1:0] note_cycles;
    logic          stop;
    logic [CW-1:0] cnt_q;
    logic          cnt_sclr;
    logic          tone_out;
    logic          busy;
    logic          done;

    logic          jump_en;
    logic [CW-1:0] jump_val;

    int n_chk  = 0;
    int n_pass = 0;

    tone_seq_ctrl #(.CNT_W(CW), .CYC_W(YW), .GAP_CLKS(GAP)) dut (
        .clk         (clk),
        .sclr        (sclr),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_period (note_period),
        .note_cycles (note_cycles),
        .stop        (stop),
        .cnt_q       (cnt_q),
        .cnt_sclr    (cnt_sclr),
        .tone_out    (tone_out),
        .busy        (busy),
        .done        (done)
    );

    // Parent-side up_counter; jump lets the bench skip ahead for long periods.
    always_ff @(posedge clk) begin
        if (cnt_sclr)     cnt_q <= '0;
        else if (jump_en) cnt_q <= jump_val;
        else              cnt_q <= cnt_q + 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a note is a timeline indexed by k = edges since accept.
    bit     m_valid = 0;
    bit     m_en    = 1;
    bit     m_act   = 0;
    longint m_k, m_per, m_len, m_end;
    longint m_cnt;

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic bit exp_wrap();
        if (!m_act) return 0;
        if (m_k < m_len) return (m_k % m_per) == m_per - 1;
        return (m_k < m_end) && (m_k - m_len == GAP - 1);
    endfunction

    function automatic bit exp_csclr();
        return sclr || !m_act || stop || exp_wrap();
    endfunction

    task automatic model_step();
        m_cnt = exp_csclr() ? 0 : ((m_cnt + 1) & ((64'd1 << CW) - 1));
        if (sclr) begin
            m_act   = 0;
            m_valid = 1;
        end else if (m_act) begin
            if (stop || m_k == m_end) m_act = 0;
            else m_k++;
        end else if (note_valid) begin
            m_per = (note_period < 2) ? 2 : longint'(note_period);
            m_len = 2 * m_per * longint'(note_cycles);
            m_end = m_len + GAP;
            m_k   = 0;
            m_act = 1;
        end
    endtask

    task automatic model_compare();
        if (!(m_valid && m_en)) return;
        check("tone_out", tone_out, (m_act && m_k < m_len) ? ((m_k / m_per) % 2) : 0);
        check("busy", busy, m_act);
        check("done", done, m_act && m_k == m_end);
        check("note_ready", note_ready, !m_act && !sclr);
        check("cnt_sclr", cnt_sclr, exp_csclr());
        check("cnt_q", cnt_q, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_note(input logic [CW-1:0] per, input logic [YW-1:0] cyc);
        note_valid  = 1'b1;
        note_period = per;
        note_cycles = cyc;
        tick();
        note_valid  = 1'b0;
    endtask

    // Plays one note from IDLE; returns tone samples for k=0..63 and k of done.
    task automatic run_note(input logic [CW-1:0] per, input logic [YW-1:0] cyc,
                            output logic [63:0] pat, output longint dk);
        pat = '0;
        dk  = -1;
        start_note(per, cyc);
        for (int k = 0; k < 500; k++) begin
            if (k < 64) pat[k] = tone_out;
            if (done) begin
                dk = k;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check(name, seen, 1);
    endtask

    logic [63:0] pat;
    longint      dk;
    bit          reached;

    initial begin
        sclr = 1'b1; note_valid = 1'b0; note_period = '0; note_cycles = '0;
        stop = 1'b0; jump_en = 1'b0; jump_val = '0;

        // Reset held for 3 cycles
        ticks(3);
        check("rst tone", tone_out, 0);
        check("rst busy", busy, 0);
        check("rst cnt", cnt_q, 0);
        check("rst ready", note_ready, 0);
        sclr = 1'b0;
        tick();
        check("ready after rst", note_ready, 1);

        // period 4, 2 cycles
        run_note(20'd4, 16'd2, pat, dk);
        check("p4c2 pattern", pat, 64'hF0F0);
        check("p4c2 done k", dk, 26);
        tick();
        check("p4c2 busy after", busy, 0);
        tick();
        check("p4c2 ready", note_ready, 1);

        // period 0 and 1 clamp to 2
        run_note(20'd0, 16'd1, pat, dk);
        check("p0 pattern", pat, 64'h0C);
        check("p0 done k", dk, 14);
        ticks(2);
        run_note(20'd1, 16'd1, pat, dk);
        check("p1 pattern", pat, 64'h0C);
        check("p1 done k", dk, 14);
        ticks(2);

        // zero cycles: gap only
        run_note(20'd100, 16'd0, pat, dk);
        check("c0 pattern", pat, 0);
        check("c0 done k", dk, 10);
        ticks(2);

        // stop on a wrap cycle
        start_note(20'd3, 16'd3);
        ticks(5);
        check("stop on wrap cnt", cnt_q, 2);
        check("stop on wrap tone", tone_out, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop busy", busy, 0);
        check("stop tone", tone_out, 0);
        check("stop done", done, 0);
        start_note(20'd2, 16'd1);
        check("accept after stop", busy, 1);
        wait_done("post-stop note done");
        ticks(2);

        // sclr mid-gap
        start_note(20'd2, 16'd1);
        ticks(8);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("sclr gap busy", busy, 0);
        check("sclr gap tone", tone_out, 0);

        // back-to-back with note_valid held across done
        note_valid = 1'b1; note_period = 20'd2; note_cycles = 16'd0;
        tick();
        wait_done("b2b first done");
        tick();
        check("b2b idle busy", busy, 0);
        check("b2b idle ready", note_ready, 1);
        tick();
        check("b2b second accept", busy, 1);
        note_valid = 1'b0;
        wait_done("b2b second done");
        ticks(2);

        // maximum period: skip the counter ahead and watch the wrap point
        start_note(20'hFFFFF, 16'd1);
        m_en     = 0;
        jump_en  = 1'b1;
        jump_val = 20'hFFFF8;
        tick();
        jump_en  = 1'b0;
        reached  = 0;
        for (int i = 0; i < 20; i++) begin
            if (tone_out) break;
            if (cnt_q == 20'hFFFFE) begin
                reached = 1;
                break;
            end
            tick();
        end
        check("maxper reach FFFFE", reached, 1);
        check("maxper tone low", tone_out, 0);
        tick();
        check("maxper tone rises", tone_out, 1);
        check("maxper cnt cleared", cnt_q, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_en = 1;
        tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            note_valid  = ($urandom_range(0, 1) == 1);
            note_period = CW'($urandom_range(0, 6));
            note_cycles = YW'($urandom_range(0, 3));
            stop        = ($urandom_range(0, 63) == 0);
            sclr        = ($urandom_range(0, 255) == 0);
            tick();
        end
        note_valid = 1'b0; stop = 1'b0; sclr = 1'b0;
        ticks(80);
        check("final idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
